// File: rtl/fd_pkg.sv
// Shared types for the fall-detection frame path.
// Sample order and frame builder state encoding.
package fd_pkg;

  typedef enum logic [1:0] {
    FILL,
    READY,
    RELEASE
  } frame_state_t;

  localparam int SAMPLE_W = 16;

  // Detector bit order: index 0 is the MSB
  typedef logic [0:SAMPLE_W-1] sample_t;

endpackage

// File: rtl/fd_sat_counter.sv
// Saturating up-counter.
// Holds at all-ones instead of wrapping.
module fd_sat_counter
  import fd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/accel_frame_builder.sv
// Collects accelerometer samples into a frame for the fall detector.
// Holds the frame under flag until done, then re-arms.
module accel_frame_builder
  import fd_pkg::*;
#(
  parameter int N_SAMPLES = 5,
  parameter int DW        = 16,
  parameter int TIMEOUT   = 64,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DW-1:0]     sample_data,
  output logic              sample_ready,
  output logic              flag,
  output logic [0:DW-1]     data [N_SAMPLES],
  input  logic              done,
  output logic              timeout_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  frame_state_t  state;
  frame_state_t  state_nxt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] wr_idx_nxt;
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_nxt;
  logic          tmo_err_nxt;
  logic          take;

  always_comb begin
    state_nxt    = state;
    wr_idx_nxt   = wr_idx;
    tmo_nxt      = tmo;
    tmo_err_nxt  = 1'b0;
    take         = 1'b0;
    sample_ready = 1'b0;
    flag         = 1'b0;
    unique case (state)
      FILL: begin
        sample_ready = 1'b1;
        take         = sample_valid;
        if (sample_valid) begin
          if (wr_idx == LAST_IDX) begin
            state_nxt  = READY;
            wr_idx_nxt = '0;
            tmo_nxt    = '0;
          end else begin
            wr_idx_nxt = wr_idx + 1'b1;
          end
        end
      end
      READY: begin
        flag    = 1'b1;
        tmo_nxt = tmo + 1'b1;
        // done outranks an expiry landing on the same cycle
        if (done) begin
          state_nxt = RELEASE;
        end else if (tmo == TMO_LAST) begin
          state_nxt   = RELEASE;
          tmo_err_nxt = 1'b1;
        end
      end
      RELEASE: begin
        // wait out a held done level so it cannot retrigger
        if (!done) begin
          state_nxt  = FILL;
          wr_idx_nxt = '0;
          tmo_nxt    = '0;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_idx      <= '0;
      tmo         <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        data[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      wr_idx      <= wr_idx_nxt;
      tmo         <= tmo_nxt;
      timeout_err <= tmo_err_nxt;
      // [0:DW-1] range puts sample MSB at index 0
      if (take) begin
        data[wr_idx] <= sample_data;
      end
    end
  end

  fd_sat_counter #(
    .W(DROP_W)
  ) u_drop (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sample_valid & ~sample_ready),
    .cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_accel_frame_builder.sv
// Self-checking bench for accel_frame_builder.
// Directed frames checked against a queue-based frame model.
module tb_accel_frame_builder;

  localparam int N      = 5;
  localparam int DW     = 16;
  localparam int TMO    = 64;
  localparam int DROP_W = 8;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DW-1:0]     sample_data = '0;
  logic              done = 1'b0;
  logic              sample_ready;
  logic              flag;
  logic [0:DW-1]     data [N];
  logic              timeout_err;
  logic [DROP_W-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  accel_frame_builder #(
    .N_SAMPLES(N),
    .DW       (DW),
    .TIMEOUT  (TMO),
    .DROP_W   (DROP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .flag        (flag),
    .data        (data),
    .done        (done),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: collected samples queue, presenting/draining flags
  logic [DW-1:0] q [$];
  logic [DW-1:0] frame [N];
  bit pres   = 1'b0;
  bit drain  = 1'b0;
  bit m_terr = 1'b0;
  int age    = 0;
  int m_drop = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", sample_ready, !pres && !drain);
        chk("flag", flag, pres);
        chk("tmo_err", timeout_err, m_terr);
        chk("drop", drop_cnt, m_drop);
        if (pres) begin
          for (int i = 0; i < N; i++) begin
            chk($sformatf("data%0d", i), data[i], frame[i]);
          end
        end
      end
      // advance model with inputs the next posedge will sample
      if (!rst_n) begin
        q.delete();
        pres   = 1'b0;
        drain  = 1'b0;
        m_terr = 1'b0;
        age    = 0;
        m_drop = 0;
      end else begin
        bit refused;
        refused = sample_valid && (pres || drain);
        m_terr  = 1'b0;
        if (pres) begin
          if (done) begin
            pres  = 1'b0;
            drain = 1'b1;
          end else if (age == TMO - 1) begin
            pres   = 1'b0;
            drain  = 1'b1;
            m_terr = 1'b1;
          end else begin
            age++;
          end
        end else if (drain) begin
          if (!done) drain = 1'b0;
        end else if (sample_valid) begin
          q.push_back(sample_data);
          if (q.size() == N) begin
            for (int i = 0; i < N; i++) frame[i] = q[i];
            q.delete();
            pres = 1'b1;
            age  = 0;
          end
        end
        if (refused && m_drop < DMAX) m_drop++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DW-1:0] s);
    sample_valid = 1'b1;
    sample_data  = s;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic release_done();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  logic [DW-1:0] t1 [N];
  logic [0:3]    nib;
  int n_flag;
  int n_terr;

  initial begin
    t1[0] = 16'h3333;
    t1[1] = 16'h4000;
    t1[2] = 16'h3000;
    t1[3] = 16'h3800;
    t1[4] = 16'h3FFF;

    step();
    chk_en = 1'b1;
    step();
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_flag", flag, 1'b0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data0", data[0], 0);
    chk("rst_data4", data[4], 0);
    rst_n = 1'b1;

    // 1) first frame, flag exactly one cycle after last sample
    for (int i = 0; i < N; i++) begin
      chk("t1_flag_low", flag, 1'b0);
      feed(t1[i]);
    end
    chk("t1_flag", flag, 1'b1);
    chk("t1_data0", data[0], 16'h3333);
    chk("t1_data4", data[4], 16'h3FFF);
    nib = data[0][0:3];
    chk("t1_msb_first", nib, 4'b0011);
    chk("t1_d1_bit1", data[1][1], 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("t1_data3_held", data[3], 16'h3800);

    // 2) done held 5 cycles; valid offered on the release cycle
    done = 1'b1;
    step();
    chk("t2_flag_fall", flag, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_low", sample_ready, 1'b0);
      step();
    end
    done         = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 16'hDEAD;
    step();
    sample_valid = 1'b0;
    chk("t2_ready_back", sample_ready, 1'b1);
    chk("t2_drop_one", drop_cnt, 1);

    // 3) no done: 64-cycle flag window, one error pulse, refill
    for (int i = 0; i < N; i++) feed(16'(16'h0100 + i));
    chk("t3_data0", data[0], 16'h0100);
    n_flag = 0;
    n_terr = 0;
    for (int i = 0; i < 70; i++) begin
      if (flag) n_flag++;
      if (timeout_err) n_terr++;
      step();
    end
    chk("t3_flag_cycles", n_flag, 64);
    chk("t3_terr_pulses", n_terr, 1);
    for (int i = 0; i < N; i++) feed(16'(16'h0200 + i));
    chk("t3_refill_flag", flag, 1'b1);
    chk("t3_refill_d4", data[4], 16'h0204);
    release_done();

    // 4) valid held high through READY/RELEASE windows
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      sample_data  = 16'(16'h1000 + i);
      step();
    end
    chk("t4_drop_sat", drop_cnt, 255);
    for (int i = 0; i < 5; i++) step();
    sample_valid = 1'b0;
    chk("t4_drop_hold", drop_cnt, 255);

    // 5) reset after 3 of 5 samples
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) feed(16'(16'h0A00 + i));
    rst_n = 1'b0;
    step();
    chk("t5_flag", flag, 1'b0);
    chk("t5_ready", sample_ready, 1'b1);
    chk("t5_drop_clr", drop_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(16'(16'h0B00 + i));
      chk("t5_no_early_flag", flag, 1'b0);
    end
    feed(16'h0B04);
    chk("t5_flag", flag, 1'b1);
    chk("t5_data0", data[0], 16'h0B00);
    release_done();

    // stale done while filling is ignored
    done = 1'b1;
    step();
    step();
    chk("fill_done_ready", sample_ready, 1'b1);
    chk("fill_done_flag", flag, 1'b0);
    done = 1'b0;

    // 6) done lands on the final timeout cycle
    for (int i = 0; i < N; i++) feed(16'(16'h0C00 + i));
    for (int i = 0; i < TMO - 1; i++) step();
    chk("t6_flag_last", flag, 1'b1);
    done = 1'b1;
    step();
    chk("t6_flag", flag, 1'b0);
    chk("t6_terr", timeout_err, 1'b0);
    step();
    chk("t6_terr2", timeout_err, 1'b0);
    done = 1'b0;
    step();
    chk("t6_ready", sample_ready, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
